// File: rtl/seg_scan_driver.sv
// Time-multiplexed scanner for an active-low hex-to-7-segment decoder.
// Inputs are captured into shadow registers once per frame; each digit slot is SHOW then dark GAP.
module seg_scan_driver #(
    parameter int N_DIG    = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GAP_CYC  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*N_DIG-1:0]   data,
    input  logic [N_DIG-1:0]     point_en,
    input  logic [N_DIG-1:0]     blank,
    input  logic                 lz_en,
    output logic [N_DIG-1:0]     an,
    output logic [3:0]           hex,
    output logic                 le,
    output logic                 point,
    output logic                 frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIG);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - GAP_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*N_DIG-1:0]   data_sh_q, data_sh_d;
    logic [N_DIG-1:0]     point_sh_q, point_sh_d;
    logic [N_DIG-1:0]     blank_sh_q, blank_sh_d;
    logic                 lz_sh_q, lz_sh_d;
    logic [N_DIG-1:0]     an_q, an_d;
    logic [3:0]           hex_q, hex_d;
    logic                 le_q, le_d;
    logic                 point_q, point_d;
    logic                 frame_start_q, frame_start_d;
    logic                 load_s;
    logic                 run_zero_s;
    logic [N_DIG-1:0]     dark_s;
    logic [3:0]           nib_s;

    // Slot sequencing and once-per-frame shadow capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                state_d = ST_SHOW;
                idx_d   = {IW{1'b0}};
                cnt_d   = {CW{1'b0}};
                load_s  = 1'b1;
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = {CW{1'b0}};
                    if (idx_q == IDX_LAST) begin
                        idx_d  = {IW{1'b0}};
                        load_s = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = {IW{1'b0}};
                cnt_d   = {CW{1'b0}};
            end
        endcase

        if (load_s) begin
            data_sh_d  = data;
            point_sh_d = point_en;
            blank_sh_d = blank;
            lz_sh_d    = lz_en;
        end else begin
            data_sh_d  = data_sh_q;
            point_sh_d = point_sh_q;
            blank_sh_d = blank_sh_q;
            lz_sh_d    = lz_sh_q;
        end
    end

    // Output decode computed from next state so registered outputs line up with the FSM
    always_comb begin
        run_zero_s = 1'b1;
        dark_s     = {N_DIG{1'b0}};
        // A run of zero, point-free digits from the top is dark; digit 0 always stays lit
        for (int i = N_DIG - 1; i >= 0; i--) begin
            run_zero_s = run_zero_s & (data_sh_d[4*i +: 4] == 4'h0) & ~point_sh_d[i];
            dark_s[i]  = blank_sh_d[i] | (lz_sh_d & run_zero_s & (i != 0));
        end
        nib_s = 4'(data_sh_d >> {idx_d, 2'b00});

        an_d          = {N_DIG{1'b1}};
        hex_d         = hex_q;
        le_d          = 1'b1;
        point_d       = 1'b0;
        frame_start_d = 1'b0;
        if (state_d == ST_SHOW) begin
            hex_d         = nib_s;
            frame_start_d = load_s;
            if (dark_s[idx_d]) begin
                an_d    = {N_DIG{1'b1}};
                le_d    = 1'b1;
                point_d = 1'b0;
            end else begin
                an_d    = ~(N_DIG'(1) << idx_d);
                le_d    = 1'b0;
                point_d = point_sh_d[idx_d];
            end
        end else begin
            an_d    = {N_DIG{1'b1}};
            le_d    = 1'b1;
            point_d = 1'b0;
        end
    end

    // State, shadow and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            idx_q         <= {IW{1'b0}};
            cnt_q         <= {CW{1'b0}};
            data_sh_q     <= {(4*N_DIG){1'b0}};
            point_sh_q    <= {N_DIG{1'b0}};
            blank_sh_q    <= {N_DIG{1'b0}};
            lz_sh_q       <= 1'b0;
            an_q          <= {N_DIG{1'b1}};
            hex_q         <= 4'h0;
            le_q          <= 1'b1;
            point_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            data_sh_q     <= data_sh_d;
            point_sh_q    <= point_sh_d;
            blank_sh_q    <= blank_sh_d;
            lz_sh_q       <= lz_sh_d;
            an_q          <= an_d;
            hex_q         <= hex_d;
            le_q          <= le_d;
            point_q       <= point_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign hex         = hex_q;
    assign le          = le_q;
    assign point       = point_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-position model predicts every output cycle,
// a negedge monitor pops predictions and compares them with the DUT.
module tb_seg_scan_driver;

    localparam int N        = 4;
    localparam int DIV      = 8;
    localparam int GAP      = 2;
    localparam int FRAME    = N * DIV;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*N-1:0] data;
    logic [N-1:0]   point_en;
    logic [N-1:0]   blank;
    logic           lz_en;
    logic [N-1:0]   an;
    logic [3:0]     hex;
    logic           le;
    logic           point;
    logic           frame_start;

    seg_scan_driver #(.N_DIG(N), .SCAN_DIV(DIV), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .point_en(point_en), .blank(blank),
        .lz_en(lz_en), .an(an), .hex(hex), .le(le), .point(point), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Expected tuple: {an, hex, le, point, frame_start}
    logic [N+6:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    // Model state: position within frame (-1 = reset/LOAD) and the frame snapshot
    int         pos = -1;
    logic [15:0] s_data;
    logic [3:0]  s_pt, s_bl;
    logic        s_lz;
    logic [3:0]  last_hex = 4'h0;

    // Predict outputs after the coming edge, then let that edge happen
    task automatic step();
        logic [N+6:0] e;
        int slot, off;
        logic lzd, dark;
        logic [3:0] nib;
        if (!rst_n) begin
            pos      = -1;
            last_hex = 4'h0;
            e = {4'b1111, 4'h0, 1'b1, 1'b0, 1'b0};
        end else begin
            pos = (pos < 0) ? 0 : (pos + 1) % FRAME;
            if (pos == 0) begin
                s_data = data; s_pt = point_en; s_bl = blank; s_lz = lz_en;
            end
            slot = pos / DIV;
            off  = pos % DIV;
            if (off >= DIV - GAP) begin
                e = {4'b1111, last_hex, 1'b1, 1'b0, 1'b0};
            end else begin
                nib      = s_data[slot*4 +: 4];
                last_hex = nib;
                lzd = s_lz && (slot != 0);
                for (int j = slot; j < N; j++)
                    if (s_data[j*4 +: 4] != 4'h0 || s_pt[j]) lzd = 1'b0;
                dark = s_bl[slot] || lzd;
                if (dark)
                    e = {4'b1111, nib, 1'b1, 1'b0, pos == 0};
                else
                    e = {~(4'b0001 << slot), nib, 1'b0, s_pt[slot], pos == 0};
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to(input int p);
        for (int k = 0; k < 2 * FRAME && pos != p; k++) step();
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] d;
        for (int i = 0; i < 4; i++)
            d[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return d;
    endfunction

    // Monitor: one comparison per DUT output cycle
    always @(negedge clk) begin
        if (mon_on) begin
            logic [N+6:0] got, want;
            got = {an, hex, le, point, frame_start};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty @%0t: got an=%b hex=%h le=%b point=%b fs=%b, want no output pending",
                         $time, an, hex, le, point, frame_start);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL cycle_out @%0t: got an=%b hex=%h le=%b point=%b fs=%b, want an=%b hex=%h le=%b point=%b fs=%b",
                             $time, an, hex, le, point, frame_start,
                             want[10:7], want[6:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; data = 16'h1234; point_en = 4'b0000; blank = 4'b0000; lz_en = 1'b0;
        mon_on = 1'b1;
        run(5);
        rst_n = 1'b1;
        run(2 * FRAME + 1);

        run_to(10);
        data = 16'hABCD;
        run(2 * FRAME);

        lz_en = 1'b1;
        data = 16'h0050; run(2 * FRAME);
        data = 16'h0000; run(2 * FRAME);
        data = 16'h0005; point_en = 4'b0010; run(2 * FRAME);

        lz_en = 1'b0; data = 16'h1234; point_en = 4'b0100; blank = 4'b0010;
        run(2 * FRAME);

        point_en = 4'b0000; blank = 4'b0000;
        run_to(17);
        rst_n = 1'b0; step();
        rst_n = 1'b1; run(FRAME + 8);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                data     = rand_data();
                point_en = 4'($urandom & $urandom & $urandom);
                blank    = 4'($urandom & $urandom & $urandom);
                lz_en    = 1'($urandom_range(0, 3) != 0);
            end
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst_n = 1'b1;
        run(FRAME);

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
